// File: rtl/mul_rr_sched.sv
// Two-port round-robin front end for one shared signed multiplier.
// Operands are held for MC_CYCLES clocks so the multiplier can be a multicycle path.

module multiplier #(
  parameter int N = 10
) (
  input  logic signed [N-1:0]   a,
  input  logic signed [N-1:0]   b,
  output logic signed [2*N-1:0] p
);
  logic [N:0]             bx;
  logic signed [2*N-1:0]  ae;
  logic signed [2*N-1:0]  pp;
  logic signed [2*N-1:0]  acc;

  assign bx = {b, 1'b0};
  assign ae = {{N{a[N-1]}}, a};

  // radix-4 Booth digits; each row is a pre-sign-extended partial product
  always_comb begin
    acc = '0;
    pp  = '0;
    for (int i = 0; i < N/2; i++) begin
      unique case (bx[2*i +: 3])
        3'b001, 3'b010: pp = ae;
        3'b011:         pp = ae <<< 1;
        3'b100:         pp = -(ae <<< 1);
        3'b101, 3'b110: pp = -ae;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2*i));
    end
    p = acc;
  end
endmodule

module mul_rr_sched #(
  parameter int N         = 10,
  parameter int MC_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           a0_valid,
  output logic           a0_ready,
  input  logic [N-1:0]   a0_a,
  input  logic [N-1:0]   a0_b,
  input  logic           a1_valid,
  output logic           a1_ready,
  input  logic [N-1:0]   a1_a,
  input  logic [N-1:0]   a1_b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N:0]   res_data,
  output logic           res_id,
  output logic           busy
);
  localparam int CW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [CW-1:0]          cnt;
  logic                   last_grant;
  logic signed [N-1:0]    op_a;
  logic signed [N-1:0]    op_b;
  logic signed [2*N-1:0]  prod;
  logic                   idle;
  logic                   g0;
  logic                   g1;
  logic                   take;

  multiplier #(.N(N)) u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  assign idle = (state == IDLE);
  assign busy = ~idle;

  // on a tie the port that did not win last time is granted
  assign g0 = a0_valid & (~a1_valid | last_grant);
  assign g1 = a1_valid & (~a0_valid | ~last_grant);

  assign a0_ready = rst_n & idle & g0;
  assign a1_ready = rst_n & idle & g1;
  assign take     = a0_ready | a1_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take) state_nx = WAIT;
      WAIT:    if (cnt == '0) state_nx = HOLD;
      HOLD:    if (res_valid & res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        op_a       <= a1_ready ? a1_a : a0_a;
        op_b       <= a1_ready ? a1_b : a0_b;
        res_id     <= a1_ready;
        last_grant <= a1_ready;
        cnt        <= CW'(MC_CYCLES - 1);
      end
      if (state == WAIT) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          res_data  <= {prod[2*N-1], prod};
          res_valid <= 1'b1;
        end
      end
      if (state == HOLD && res_ready) res_valid <= 1'b0;
    end
  end
endmodule
